// File: rtl/ifu_axi_rd_bridge.sv
// Instruction-fetch burst read bridge: one cache line request -> one AXI4 INCR AR burst, R beats forwarded with zero latency.
// Optional sticky response/last-consistency error flag under YSYX_23060077_RRESP_CHK_EN.
module ifu_axi_rd_bridge #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned AXI_LEN_WIDTH  = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [AXI_LEN_WIDTH-1:0]  req_len_i,
  output logic                      req_ready_o,
  output logic [DATA_WIDTH-1:0]     req_data_o,
  output logic                      req_last_o,
  output logic                      arvalid_o,
  input  logic                      arready_i,
  output logic [AXI_ADDR_WIDTH-1:0] araddr_o,
  output logic [3:0]                arid_o,
  output logic [7:0]                arlen_o,
  output logic [2:0]                arsize_o,
  output logic [1:0]                arburst_o,
  input  logic                      rvalid_i,
  output logic                      rready_o,
  input  logic [DATA_WIDTH-1:0]     rdata_i,
  input  logic [1:0]                rresp_i,
  input  logic                      rlast_i,
  input  logic [3:0]                rid_i
`ifdef YSYX_23060077_RRESP_CHK_EN
  ,
  output logic                      bus_err_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } state_t;

  state_t                    r_state;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [AXI_LEN_WIDTH-1:0]  r_len;
  logic [7:0]                r_beat_cnt;
  logic                      r_arvalid;
  logic                      r_rready;
  logic                      w_beat;

  // A beat is accepted only while in DATA, since rready is high exactly there.
  assign w_beat = r_rready & rvalid_i;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_len      <= '0;
      r_beat_cnt <= '0;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            r_addr    <= {req_addr_i[AXI_ADDR_WIDTH-1:2], 2'b00};
            r_len     <= req_len_i;
            r_arvalid <= 1'b1;
            r_state   <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (arready_i) begin
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b1;
            r_beat_cnt <= '0;
            r_state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (rvalid_i) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
            if (rlast_i) begin
              r_rready <= 1'b0;
              r_state  <= S_IDLE;
            end
          end
        end
        default: begin
          r_arvalid <= 1'b0;
          r_rready  <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign arvalid_o   = r_arvalid;
  assign araddr_o    = r_addr;
  assign arlen_o     = 8'(r_len);
  assign arid_o      = 4'd0;
  assign arsize_o    = 3'b010;
  assign arburst_o   = 2'b01;
  assign rready_o    = r_rready;
  assign req_ready_o = w_beat;
  assign req_last_o  = w_beat & rlast_i;
  assign req_data_o  = w_beat ? rdata_i : '0;

`ifdef YSYX_23060077_RRESP_CHK_EN
  logic r_bus_err;
  logic w_unused;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_bus_err <= 1'b0;
    end else if (w_beat && ((rresp_i != 2'b00) || (rlast_i != (r_beat_cnt == 8'(r_len))))) begin
      r_bus_err <= 1'b1;
    end
  end

  assign bus_err_o = r_bus_err;
  assign w_unused  = ^{rid_i, req_addr_i[1:0]};
`else
  logic w_unused;
  assign w_unused = ^{rid_i, req_addr_i[1:0], rresp_i, r_beat_cnt};
`endif

endmodule

// File: tb/tb_ifu_axi_rd_bridge.sv
// Bench for ifu_axi_rd_bridge: table of bursts plus hand sequences; R beats are scored through an expected-beat queue.
// Build with YSYX_23060077_RRESP_CHK_EN defined to also exercise bus_err_o.
module tb_ifu_axi_rd_bridge;

  logic        clock;
  logic        reset;
  logic        req_valid_i;
  logic [31:0] req_addr_i;
  logic [7:0]  req_len_i;
  logic        req_ready_o;
  logic [31:0] req_data_o;
  logic        req_last_o;
  logic        arvalid_o;
  logic        arready_i;
  logic [31:0] araddr_o;
  logic [3:0]  arid_o;
  logic [7:0]  arlen_o;
  logic [2:0]  arsize_o;
  logic [1:0]  arburst_o;
  logic        rvalid_i;
  logic        rready_o;
  logic [31:0] rdata_i;
  logic [1:0]  rresp_i;
  logic        rlast_i;
  logic [3:0]  rid_i;
`ifdef YSYX_23060077_RRESP_CHK_EN
  logic        bus_err_o;
`endif

  ifu_axi_rd_bridge #(
    .AXI_ADDR_WIDTH(32),
    .DATA_WIDTH    (32),
    .AXI_LEN_WIDTH (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid_i(req_valid_i),
    .req_addr_i (req_addr_i),
    .req_len_i  (req_len_i),
    .req_ready_o(req_ready_o),
    .req_data_o (req_data_o),
    .req_last_o (req_last_o),
    .arvalid_o  (arvalid_o),
    .arready_i  (arready_i),
    .araddr_o   (araddr_o),
    .arid_o     (arid_o),
    .arlen_o    (arlen_o),
    .arsize_o   (arsize_o),
    .arburst_o  (arburst_o),
    .rvalid_i   (rvalid_i),
    .rready_o   (rready_o),
    .rdata_i    (rdata_i),
    .rresp_i    (rresp_i),
    .rlast_i    (rlast_i),
    .rid_i      (rid_i)
`ifdef YSYX_23060077_RRESP_CHK_EN
    ,
    .bus_err_o  (bus_err_o)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    int unsigned ar_wait;
    logic [7:0]  gap;         // bit k%8 = rvalid in k-th DATA cycle
    logic [31:0] d0;
    logic [7:0]  bad_resp;    // beat index carrying rresp=2'b10, 8'hFF = none
    logic [31:0] exp_araddr;
  } vec_t;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [32:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: every accepted beat must match the next queued expectation.
  always @(negedge clock) begin
    if (!reset) begin
      if (req_ready_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(req_data_o), 64'hDEAD);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          chk("beat_data", 64'(req_data_o), 64'(e[31:0]));
          chk("beat_last", 64'(req_last_o), 64'(e[32]));
        end
      end else begin
        chk("idle_data", 64'(req_data_o), 64'd0);
        chk("idle_last", 64'(req_last_o), 64'd0);
      end
    end
  end

  task automatic do_req(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] exp_a);
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    req_len_i   = len;
    step();
    req_valid_i = 1'b0;
    chk("ar_valid_up", 64'(arvalid_o), 64'd1);
    chk("ar_addr", 64'(araddr_o), 64'(exp_a));
    chk("ar_len", 64'(arlen_o), 64'(len));
    chk("rready_in_addr", 64'(rready_o), 64'd0);
  endtask

  task automatic do_ar(input int unsigned wait_cyc, input logic [31:0] exp_a);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < wait_cyc; i++) begin
      arready_i = 1'b0;
      @(negedge clock);
      if (arvalid_o) cnt++;
      chk("ar_addr_stable", 64'(araddr_o), 64'(exp_a));
      chk("rready_backpress", 64'(rready_o), 64'd0);
      step();
    end
    arready_i = 1'b1;
    @(negedge clock);
    if (arvalid_o) cnt++;
    step();
    arready_i = 1'b0;
    chk("ar_cycles", 64'(cnt), 64'(wait_cyc + 1));
    chk("ar_valid_down", 64'(arvalid_o), 64'd0);
    chk("rready_in_data", 64'(rready_o), 64'd1);
  endtask

  // Feeds beats 0..len (or up to early_last, which carries rlast), gapped by the mask.
  task automatic do_data(input logic [7:0] len, input logic [7:0] gap, input logic [31:0] d0,
                         input logic [7:0] bad_resp, input logic [7:0] early_last);
    int unsigned idx;
    int unsigned k;
    logic [7:0]  g;
    logic        done;
    idx  = 0;
    k    = 0;
    g    = gap;
    done = 1'b0;
    while (!done && k < 64) begin
      rvalid_i = g[k % 8];
      rresp_i  = 2'b00;
      if (rvalid_i) begin
        rdata_i = d0 + 32'(idx);
        rlast_i = (idx == 32'(len)) || (idx == 32'(early_last));
        if (idx == 32'(bad_resp)) rresp_i = 2'b10;
        exp_q.push_back({rlast_i, rdata_i});
        done = rlast_i;
        idx++;
      end else begin
        rdata_i = $urandom;
        rlast_i = 1'($urandom_range(0, 1));
      end
      step();
      k++;
    end
    rvalid_i = 1'b0;
    rlast_i  = 1'b0;
    rresp_i  = 2'b00;
    if (!done) chk("data_timeout", 64'(idx), 64'(len) + 64'd1);
    chk("beats_consumed", 64'(exp_q.size()), 64'd0);
    chk("idle_rready", 64'(rready_o), 64'd0);
    chk("idle_arvalid", 64'(arvalid_o), 64'd0);
  endtask

  task automatic chk_reset_outputs();
    @(negedge clock);
    chk("rst_arvalid", 64'(arvalid_o), 64'd0);
    chk("rst_rready", 64'(rready_o), 64'd0);
    chk("rst_req_ready", 64'(req_ready_o), 64'd0);
    chk("rst_araddr", 64'(araddr_o), 64'd0);
    chk("rst_arlen", 64'(arlen_o), 64'd0);
    chk("rst_arid", 64'(arid_o), 64'd0);
    chk("rst_arsize", 64'(arsize_o), 64'd2);
    chk("rst_arburst", 64'(arburst_o), 64'd1);
`ifdef YSYX_23060077_RRESP_CHK_EN
    chk("rst_bus_err", 64'(bus_err_o), 64'd0);
`endif
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{32'h3000_0006, 8'd0, 0, 8'hFF, 32'h0000_0413, 8'hFF, 32'h3000_0004};
    vecs[1] = '{32'h8000_0010, 8'd3, 0, 8'hED, 32'hA000_0000, 8'hFF, 32'h8000_0010};
    vecs[2] = '{32'h8000_0103, 8'd1, 5, 8'hFF, 32'h1111_0000, 8'hFF, 32'h8000_0100};
    vecs[3] = '{32'h1234_5672, 8'd7, 2, 8'h5B, 32'hCAFE_0000, 8'hFF, 32'h1234_5670};
    vecs[4] = '{32'hFFFF_FFFF, 8'd3, 1, 8'hFF, 32'h0BAD_0000, 8'd0, 32'hFFFF_FFFC};

    reset       = 1'b1;
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    req_len_i   = '0;
    arready_i   = 1'b0;
    rvalid_i    = 1'b0;
    rdata_i     = '0;
    rresp_i     = 2'b00;
    rlast_i     = 1'b0;
    rid_i       = 4'h5;
    step();
    step();
    chk_reset_outputs();
    step();
    reset = 1'b0;
    step();

    for (int i = 0; i < 5; i++) begin
      do_req(vecs[i].addr, vecs[i].len, vecs[i].exp_araddr);
      do_ar(vecs[i].ar_wait, vecs[i].exp_araddr);
      do_data(vecs[i].len, vecs[i].gap, vecs[i].d0, vecs[i].bad_resp, 8'hFF);
`ifdef YSYX_23060077_RRESP_CHK_EN
      chk("bus_err_vec", 64'(bus_err_o), (vecs[i].bad_resp != 8'hFF) ? 64'd1 : 64'd0);
`endif
      step();
    end

`ifdef YSYX_23060077_RRESP_CHK_EN
    // Error flag survives a clean burst and clears only on reset.
    do_req(32'h4000_0000, 8'd0, 32'h4000_0000);
    do_ar(0, 32'h4000_0000);
    do_data(8'd0, 8'hFF, 32'h0000_0001, 8'hFF, 8'hFF);
    chk("bus_err_sticky", 64'(bus_err_o), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("bus_err_cleared", 64'(bus_err_o), 64'd0);
    step();
`endif

    // Premature rlast on beat 2 of a 4-beat burst ends it early.
    do_req(32'h5000_0020, 8'd3, 32'h5000_0020);
    do_ar(0, 32'h5000_0020);
    do_data(8'd3, 8'hFF, 32'h7700_0000, 8'hFF, 8'd1);
`ifdef YSYX_23060077_RRESP_CHK_EN
    chk("bus_err_early_last", 64'(bus_err_o), 64'd1);
`endif
    step();

    // AR/R handshakes in IDLE must be inert.
    arready_i = 1'b1;
    rvalid_i  = 1'b1;
    rlast_i   = 1'b1;
    rdata_i   = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("idle_ar_inert", 64'(arvalid_o), 64'd0);
      chk("idle_r_inert", 64'(req_ready_o), 64'd0);
      step();
    end
    arready_i = 1'b0;
    rvalid_i  = 1'b0;
    rlast_i   = 1'b0;
    chk("idle_stays_idle", 64'(rready_o), 64'd0);

    // Request raised in the last-beat cycle is taken only from the following IDLE cycle.
    do_req(32'h6000_0040, 8'd0, 32'h6000_0040);
    do_ar(0, 32'h6000_0040);
    rvalid_i    = 1'b1;
    rdata_i     = 32'h0000_0AAA;
    rlast_i     = 1'b1;
    exp_q.push_back({1'b1, 32'h0000_0AAA});
    req_valid_i = 1'b1;
    req_addr_i  = 32'h6000_0087;
    req_len_i   = 8'd1;
    step();
    rvalid_i = 1'b0;
    rlast_i  = 1'b0;
    chk("b2b_gap_arvalid", 64'(arvalid_o), 64'd0);
    chk("b2b_gap_rready", 64'(rready_o), 64'd0);
    do_req(32'h6000_0087, 8'd1, 32'h6000_0084);
    do_ar(2, 32'h6000_0084);
    do_data(8'd1, 8'hFF, 32'h0000_0B00, 8'hFF, 8'hFF);
    step();

    // Reset after beat 2 of an 8-beat burst drops the remainder.
    do_req(32'h7000_0100, 8'd7, 32'h7000_0100);
    do_ar(0, 32'h7000_0100);
    for (int unsigned b = 0; b < 2; b++) begin
      rvalid_i = 1'b1;
      rdata_i  = 32'hBEEF_0000 + b;
      rlast_i  = 1'b0;
      exp_q.push_back({1'b0, rdata_i});
      step();
    end
    rvalid_i = 1'b0;
    reset    = 1'b1;
    step();
    chk("midrst_arvalid", 64'(arvalid_o), 64'd0);
    chk("midrst_rready", 64'(rready_o), 64'd0);
    chk("midrst_araddr", 64'(araddr_o), 64'd0);
    rvalid_i = 1'b1;
    rdata_i  = 32'hBEEF_0002;
    @(negedge clock);
    chk("midrst_drop", 64'(req_ready_o), 64'd0);
    step();
    reset    = 1'b0;
    rvalid_i = 1'b0;
    chk("midrst_queue", 64'(exp_q.size()), 64'd0);
    step();
    do_req(32'h7000_0200, 8'd2, 32'h7000_0200);
    do_ar(1, 32'h7000_0200);
    do_data(8'd2, 8'hB5, 32'h0000_C000, 8'hFF, 8'hFF);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
